fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. Holds the program counter and drives the instruction-memory address. Latches the returned instruction into the IF/ID pipeline register. Handles stall holds, branch redirects with bubble insertion, and freezing fetch once HLT has been fetched.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word driven into IF/ID for a bubble.
- HLT_OPCODE, 4'hF, value of instr[15:12] identifying HLT.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- stall, input, 1, hazard-unit hold; PC and IF/ID keep their values.
- redirect, input, 1, taken branch/jump resolved downstream; load redirect_pc and flush IF/ID.
- redirect_pc, input, 16, redirect target; bit 0 is ignored (forced to 0).
- imem_addr, output, 16, instruction-memory address; equals current PC.
- imem_data, input, 16, instruction word at imem_addr; combinational, valid in the same cycle.
- pc, output, 16, current PC, exported for the top-level pc port.
- ifid_instr, output, 16, IF/ID instruction.
- ifid_pc_plus2, output, 16, IF/ID PC+2 of the latched instruction.
- ifid_valid, output, 1, IF/ID holds a real instruction (0 = bubble).
- fetch_halted, output, 1, HLT has been fetched; PC is frozen.

## Operation
- State: PC register (16b), IF/ID register (instr, pc_plus2, valid), halted flag.
- pc_next = PC + 2, modulo 2^16. 16'hFFFE wraps to 16'h0000 with no flag.
- Rising-edge actions, highest priority first:
  1. redirect=1, regardless of stall and halted:
     - PC <= {redirect_pc[15:1],1'b0}; halted <= 0.
     - IF/ID <= bubble (instr=NOP_INSTR, pc_plus2=0, valid=0).
  2. stall=1: PC, IF/ID and halted all hold.
  3. halted=1:
     - PC holds.
     - IF/ID <= bubble, so downstream drains past the HLT.
  4. Normal fetch:
     - IF/ID <= (imem_data, pc_next, 1).
     - If imem_data[15:12]==HLT_OPCODE: PC holds and halted <= 1.
     - Otherwise PC <= pc_next.
- A fetched HLT is passed to IF/ID exactly once with valid=1. Later cycles insert bubbles until a redirect arrives.
- A redirect while halted squashes the HLT path (e.g. HLT fetched behind a taken branch) and resumes fetch at the target.
- imem_addr = pc = PC register, combinational from state.
- The block issues no memory enable or write. Instruction memory is read-only from this block.

## Timing
- Reset (rst_n=0, asynchronous): PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0, fetch_halted=0. imem_addr=pc=RESET_PC immediately.
- Fetch latency: the instruction at PC=p appears on ifid_instr one edge after PC=p, provided stall=0 and redirect=0.
- Throughput: one instruction per cycle when unstalled.
- Redirect asserted in cycle n:
  - The IF/ID contents after edge n are a bubble.
  - PC=target after edge n.
  - The target's instruction is in IF/ID after edge n+1.
- Stall asserted for k cycles: all outputs frozen for those k edges. Fetch resumes on the first edge with stall=0.
- Simultaneous stall and redirect: redirect wins.
- rst_n deasserted mid-cycle: first fetch occurs on the first rising edge with rst_n=1.

## Test plan
- Reset and sequential fetch:
  - Stimulus: imem returns 16'h1000+addr; release rst_n.
  - Response: after edges 1, 2, 3, ifid_instr = 16'h1000, 16'h1002, 16'h1004; ifid_pc_plus2 = 2, 4, 6; valid=1; pc = 2, 4, 6.
- Stall:
  - Stimulus: assert stall for 3 cycles while PC=16'h0006.
  - Response: pc stays 16'h0006 and IF/ID stays unchanged for 3 edges. The next edge latches the word at 16'h0006 with pc_plus2=16'h0008.
- Redirect:
  - Stimulus: redirect=1, redirect_pc=16'h0041, at PC=16'h0010.
  - Response: next edge gives pc=16'h0040, ifid_valid=0, ifid_instr=16'h0000. The following edge gives ifid_instr=word@16'h0040, pc_plus2=16'h0042.
- Stall plus redirect in the same cycle:
  - Stimulus: stall=1, redirect=1, redirect_pc=16'h0100.
  - Response: pc=16'h0100 and a bubble in IF/ID after one edge.
- HLT:
  - Stimulus: word 16'hF000 at 16'h0008.
  - Response: IF/ID gets 16'hF000 with valid=1 once. fetch_halted=1, pc stays 16'h0008, and later edges give valid=0.
  - Then a redirect to 16'h0020 clears fetch_halted and fetch resumes at 16'h0020.
- Wrap and async reset:
  - Stimulus: redirect to 16'hFFFE, then one normal edge.
  - Response: pc=16'h0000 and ifid_pc_plus2=16'h0000.
  - Then pulse rst_n low mid-cycle: all outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem_addr, and fills the IF/ID register.
// Handles stall holds, redirect bubbles, and freezing fetch once HLT has been fetched.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus2: 16'h0000, valid: 1'b0};

  logic [15:0] pc_q;
  logic [15:0] pc_next;
  ifid_t       ifid_q;
  logic        halted_q;
  logic        is_hlt;

  // Natural 16-bit wrap: FFFE + 2 = 0000.
  assign pc_next = pc_q + 16'd2;
  assign is_hlt  = (imem_data[15:12] == HLT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ifid_q   <= BUBBLE;
      halted_q <= 1'b0;
    end else if (redirect) begin
      // Redirect beats stall and also squashes a halt fetched on a wrong path.
      pc_q     <= {redirect_pc[15:1], 1'b0};
      ifid_q   <= BUBBLE;
      halted_q <= 1'b0;
    end else if (stall) begin
      pc_q     <= pc_q;
      ifid_q   <= ifid_q;
      halted_q <= halted_q;
    end else if (halted_q) begin
      // HLT already went down once; keep feeding bubbles so the pipe drains.
      ifid_q <= BUBBLE;
    end else begin
      ifid_q <= '{instr: imem_data, pc_plus2: pc_next, valid: 1'b1};
      if (is_hlt) halted_q <= 1'b1;
      else        pc_q     <= pc_next;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus2 = ifid_q.pc_plus2;
  assign ifid_valid    = ifid_q.valid;
  assign fetch_halted  = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns 16'h1000+addr, with an optional HLT at 16'h0008.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data, pc, ifid_instr, ifid_pc_plus2;
  logic        ifid_valid, fetch_halted;
  logic        hlt_en;
  int          checks = 0;
  int          errors = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid(ifid_valid), .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_data = imem_addr + 16'h1000;
    if (hlt_en && imem_addr == 16'h0008) imem_data = 16'hF000;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the full IF/ID + PC view in one go.
  task automatic chk_state(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                           input logic [15:0] e_pp2, input logic e_vld, input logic e_hlt);
    chk({tag, ".pc"},     pc,            e_pc);
    chk({tag, ".addr"},   imem_addr,     e_pc);
    chk({tag, ".instr"},  ifid_instr,    e_instr);
    chk({tag, ".pp2"},    ifid_pc_plus2, e_pp2);
    chk({tag, ".valid"},  ifid_valid,    e_vld);
    chk({tag, ".halted"}, fetch_halted,  e_hlt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt_en = 1'b0;
    #2;
    chk_state("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    chk_state("reset_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Sequential fetch
    step(); chk_state("seq1", 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0);
    step(); chk_state("seq2", 16'h0004, 16'h1002, 16'h0004, 1'b1, 1'b0);
    step(); chk_state("seq3", 16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0);

    // Stall three edges at PC=6
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("stall", 16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step(); chk_state("unstall", 16'h0008, 16'h1006, 16'h0008, 1'b1, 1'b0);

    // Advance to PC=0x10
    step(); step(); step(); step();
    chk_state("adv", 16'h0010, 16'h100E, 16'h0010, 1'b1, 1'b0);

    // Redirect with odd target
    redirect = 1'b1; redirect_pc = 16'h0041;
    step(); chk_state("redir", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); chk_state("redir_tgt", 16'h0042, 16'h1040, 16'h0042, 1'b1, 1'b0);

    // Stall and redirect together
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    step(); chk_state("stall_redir", 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    stall = 1'b0; redirect = 1'b0;

    // HLT at 0x0008
    hlt_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h0008;
    step(); chk_state("to_hlt", 16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); chk_state("hlt", 16'h0008, 16'hF000, 16'h000A, 1'b1, 1'b1);
    step(); chk_state("hlt_drain1", 16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step(); chk_state("hlt_drain2", 16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b1);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step(); chk_state("hlt_redir", 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); chk_state("resume", 16'h0022, 16'h1020, 16'h0022, 1'b1, 1'b0);
    hlt_en = 1'b0;

    // PC wrap
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step(); chk_state("to_wrap", 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0);
    redirect = 1'b0;
    step(); chk_state("wrap", 16'h0000, 16'h0FFE, 16'h0000, 1'b1, 1'b0);
    step(); chk_state("post_wrap", 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0);

    // Async reset mid-cycle, checked well before the next rising edge
    #2 rst_n = 1'b0;
    #1 chk_state("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step(); chk_state("after_rst", 16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
